dso_chan_scheduler: RTL and testbench



---
 rtl/dso_sched_pkg.sv | 22 ++
 rtl/rr_pick4.sv | 30 +++
 rtl/dso_chan_scheduler.sv | 141 ++++++++++++++
 tb/tb_dso_chan_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dso_sched_pkg.sv
// dso_sched_pkg: shared types and helpers for the DSO acquisition channel
// scheduler.
//   state_t : scheduler FSM states (idle / settle blanking / dwell counting)
//   NCH     : number of ADC channels sharing the mux
//   SEL_W   : width of the mux select
//   onehot4 : select index to one-hot grant vector
package dso_sched_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_t;

  function automatic logic [NCH-1:0] onehot4(input logic [SEL_W-1:0] sel);
    onehot4 = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin picker for four requesters.
//   eligible [3:0] : requesters allowed to win this round
//   last     [1:0] : previously served index; search starts at last+1
//   pick     [1:0] : first eligible index in order last+1 .. last+4 (mod 4)
//   any            : at least one requester is eligible
module rr_pick4
  import dso_sched_pkg::*;
(
  input  logic [NCH-1:0]   eligible,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] idx_s;

  // Scan from the farthest offset down to the nearest so the nearest
  // eligible index is the one left in pick; offset 4 wraps to last itself.
  always_comb begin
    pick  = last;
    idx_s = last;
    for (int i = NCH; i >= 1; i--) begin
      idx_s = last + SEL_W'(i);
      pick  = eligible[idx_s] ? idx_s : pick;
    end
  end

  assign any = |eligible;

endmodule

// File: rtl/dso_chan_scheduler.sv
// dso_chan_scheduler: round-robin owner of the 4:1 acquisition channel mux.
// A granted channel holds the mux for max(dwell_len,1) qualified samples;
// after each select change the path is blanked for SETTLE cycles.
//   clk, rst    : clock, synchronous active-high reset
//   ch_req      : per-channel request (level)
//   ch_en       : per-channel enable; dropping the owner's bit aborts its slot
//   dwell_len   : samples per slot, latched at grant
//   sample_vld  : ADC sample strobe, counted only while sel_vld=1
//   sel, grant  : registered mux select and one-hot grant (zero when idle)
//   sel_vld     : selected channel has settled
//   slot_done   : one-cycle pulse, slot finished normally
//   slot_abort  : one-cycle pulse, slot cut short by ch_en drop
module dso_chan_scheduler
  import dso_sched_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     ch_req,
  input  logic [NCH-1:0]     ch_en,
  input  logic [DWELL_W-1:0] dwell_len,
  input  logic               sample_vld,
  output logic [SEL_W-1:0]   sel,
  output logic [NCH-1:0]     grant,
  output logic               sel_vld,
  output logic               slot_done,
  output logic               slot_abort
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;

  state_t             state_r;
  logic [SEL_W-1:0]   sel_r;
  logic [SEL_W-1:0]   last_r;
  logic [NCH-1:0]     grant_r;
  logic               sel_vld_r;
  logic               slot_done_r;
  logic               slot_abort_r;
  logic [SW-1:0]      settle_cnt_r;
  logic [DWELL_W-1:0] dwell_cnt_r;
  logic [DWELL_W-1:0] dwell_len_r;

  logic [NCH-1:0]     eligible_s;
  logic [SEL_W-1:0]   pick_s;
  logic               any_s;

  assign eligible_s = ch_req & ch_en;

  rr_pick4 u_pick (
    .eligible (eligible_s),
    .last     (last_r),
    .pick     (pick_s),
    .any      (any_s)
  );

  // Scheduler FSM with all outputs registered; abort is tested before
  // completion so it wins when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sel_r        <= 2'd0;
      last_r       <= 2'd3;
      grant_r      <= 4'd0;
      sel_vld_r    <= 1'b0;
      slot_done_r  <= 1'b0;
      slot_abort_r <= 1'b0;
      settle_cnt_r <= '0;
      dwell_cnt_r  <= '0;
      dwell_len_r  <= '0;
    end else begin
      slot_done_r  <= 1'b0;
      slot_abort_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            sel_r        <= pick_s;
            grant_r      <= onehot4(pick_s);
            dwell_len_r  <= (dwell_len == '0) ? DWELL_W'(1) : dwell_len;
            dwell_cnt_r  <= '0;
            settle_cnt_r <= '0;
            if (SETTLE == 0) begin
              sel_vld_r <= 1'b1;
              state_r   <= ST_DWELL;
            end else begin
              state_r   <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (!ch_en[sel_r]) begin
            slot_abort_r <= 1'b1;
            grant_r      <= 4'd0;
            sel_vld_r    <= 1'b0;
            last_r       <= sel_r;
            state_r      <= ST_IDLE;
          end else if (settle_cnt_r == SETTLE_LAST) begin
            sel_vld_r <= 1'b1;
            state_r   <= ST_DWELL;
          end else begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
          end
        end
        ST_DWELL: begin
          if (!ch_en[sel_r]) begin
            slot_abort_r <= 1'b1;
            grant_r      <= 4'd0;
            sel_vld_r    <= 1'b0;
            last_r       <= sel_r;
            state_r      <= ST_IDLE;
          end else if (sample_vld) begin
            // Compare against the latched length, so the counter cannot wrap.
            if (dwell_cnt_r == dwell_len_r - DWELL_W'(1)) begin
              slot_done_r <= 1'b1;
              grant_r     <= 4'd0;
              sel_vld_r   <= 1'b0;
              last_r      <= sel_r;
              state_r     <= ST_IDLE;
            end else begin
              dwell_cnt_r <= dwell_cnt_r + DWELL_W'(1);
            end
          end
        end
        default: begin
          grant_r   <= 4'd0;
          sel_vld_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel        = sel_r;
  assign grant      = grant_r;
  assign sel_vld    = sel_vld_r;
  assign slot_done  = slot_done_r;
  assign slot_abort = slot_abort_r;

endmodule

// File: tb/tb_dso_chan_scheduler.sv
// tb_dso_chan_scheduler: self-checking bench for dso_chan_scheduler
// (SETTLE=2, DWELL_W=8). Expected grant channels go into a scoreboard queue
// when the request pattern is applied and are popped when a grant appears.
module tb_dso_chan_scheduler;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ch_req;
  logic [3:0] ch_en;
  logic [7:0] dwell_len;
  logic       sample_vld;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       sel_vld;
  logic       slot_done;
  logic       slot_abort;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  bit tog    = 1'b0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
    logic [7:0] dwell;
    bit         toggle;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs[14];

  dso_chan_scheduler #(.SETTLE(SETTLE), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_req     (ch_req),
    .ch_en      (ch_en),
    .dwell_len  (dwell_len),
    .sample_vld (sample_vld),
    .sel        (sel),
    .grant      (grant),
    .sel_vld    (sel_vld),
    .slot_done  (slot_done),
    .slot_abort (slot_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants checked every cycle once reset has been applied.
  always @(negedge clk) begin
    if (mon_on) begin
      check("done_and_abort", {31'd0, slot_done & slot_abort}, 32'd0);
      check("grant_shape", {31'd0, (grant == 4'd0) || (grant == (4'b0001 << sel))}, 32'd1);
    end
  end

  // Wait for the next grant (expected one cycle after the current one) and
  // compare it with the head of the scoreboard.
  task automatic wait_grant();
    int w;
    logic [1:0] e;
    w = 0;
    while (grant == 4'd0 && w < 8) begin
      tick();
      w++;
    end
    if (grant == 4'd0) begin
      check("grant_timeout", {28'd0, grant}, 32'd1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end else begin
      check("grant_latency", w, 32'd1);
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("grant_sel", {30'd0, sel}, {30'd0, e});
        check("grant_vec", {28'd0, grant}, {28'd0, 4'b0001 << e});
      end
    end
  endtask

  // Run one complete slot and check settle latency, sample count and the
  // slot_done cycle.
  task automatic run_slot(input vec_t v);
    int t, nsamp, nvld, first_vld, exp_n;
    logic [3:0] g0;
    ch_req    = v.req;
    ch_en     = v.en;
    dwell_len = v.dwell;
    exp_q.push_back(v.exp_ch);
    wait_grant();
    g0 = 4'b0001 << v.exp_ch;
    exp_n = (v.dwell == 8'd0) ? 1 : int'(v.dwell);
    nsamp = 0; nvld = 0; first_vld = -1; t = 0;
    while (t < 300) begin
      sample_vld = v.toggle ? tog : 1'b1;
      tog = ~tog;
      if (sel_vld) begin
        nvld++;
        if (sample_vld) nsamp++;
        if (first_vld < 0) first_vld = t;
      end
      if (grant != g0) check("grant_held", {28'd0, grant}, {28'd0, g0});
      tick();
      t++;
      if (slot_done) break;
    end
    check("slot_done_seen", {31'd0, slot_done}, 32'd1);
    check("settle_latency", first_vld, SETTLE);
    check("counted_samples", nsamp, exp_n);
    if (!v.toggle) check("vld_cycles", nvld, exp_n);
    check("done_grant_zero", {28'd0, grant}, 32'd0);
    check("done_vld_zero", {31'd0, sel_vld}, 32'd0);
    check("done_no_abort", {31'd0, slot_abort}, 32'd0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{4'hF, 4'hF, 8'd3, 1'b0, 2'd0};
    vecs[1]  = '{4'hF, 4'hF, 8'd3, 1'b0, 2'd1};
    vecs[2]  = '{4'hF, 4'hF, 8'd3, 1'b0, 2'd2};
    vecs[3]  = '{4'hF, 4'hF, 8'd3, 1'b0, 2'd3};
    vecs[4]  = '{4'hF, 4'hF, 8'd3, 1'b0, 2'd0};
    vecs[5]  = '{4'hF, 4'hA, 8'd2, 1'b0, 2'd1};
    vecs[6]  = '{4'hF, 4'hA, 8'd2, 1'b0, 2'd3};
    vecs[7]  = '{4'hF, 4'hA, 8'd2, 1'b0, 2'd1};
    vecs[8]  = '{4'hF, 4'hA, 8'd2, 1'b0, 2'd3};
    vecs[9]  = '{4'h4, 4'hF, 8'd0, 1'b1, 2'd2};
    vecs[10] = '{4'h4, 4'hF, 8'd0, 1'b1, 2'd2};
    vecs[11] = '{4'h4, 4'hF, 8'd0, 1'b1, 2'd2};
    vecs[12] = '{4'hF, 4'hF, 8'd1, 1'b0, 2'd3};
    vecs[13] = '{4'hF, 4'hF, 8'd1, 1'b0, 2'd0};

    // Reset with random inputs; outputs must stay zero.
    rst = 1'b1;
    ch_req = 4'($urandom); ch_en = 4'($urandom);
    dwell_len = 8'($urandom); sample_vld = 1'($urandom);
    tick();
    mon_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst_outputs", {23'd0, sel, grant, sel_vld, slot_done, slot_abort}, 32'd0);
      ch_req = 4'($urandom); ch_en = 4'($urandom);
      dwell_len = 8'($urandom); sample_vld = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    ch_req = 4'h0;
    tick();
    check("post_rst_outputs", {23'd0, sel, grant, sel_vld, slot_done, slot_abort}, 32'd0);

    // Table-driven slots: full round robin, masked channels, dwell_len=0.
    foreach (vecs[i]) run_slot(vecs[i]);

    // Abort: ch1 loses its enable after one counted sample.
    dwell_len = 8'd4; sample_vld = 1'b1;
    exp_q.push_back(2'd1);
    wait_grant();
    n = 0;
    while (!sel_vld && n < 8) begin tick(); n++; end
    check("abort_vld_reached", {31'd0, sel_vld}, 32'd1);
    tick();
    ch_en = 4'b1101;
    tick();
    check("abort_pulse", {31'd0, slot_abort}, 32'd1);
    check("abort_no_done", {31'd0, slot_done}, 32'd0);
    check("abort_grant_zero", {28'd0, grant}, 32'd0);
    check("abort_vld_zero", {31'd0, sel_vld}, 32'd0);
    exp_q.push_back(2'd2);
    wait_grant();
    check("abort_one_pulse", {31'd0, slot_abort}, 32'd0);
    ch_en = 4'hF;
    n = 0;
    while (!slot_done && n < 30) begin tick(); n++; end
    check("ch2_done", {31'd0, slot_done}, 32'd1);

    // Reset lands in the same cycle as ch3's final sample.
    dwell_len = 8'd2;
    exp_q.push_back(2'd3);
    wait_grant();
    n = 0;
    while (!sel_vld && n < 8) begin tick(); n++; end
    check("rst_vld_reached", {31'd0, sel_vld}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_no_done", {31'd0, slot_done}, 32'd0);
    check("rst_grant_zero", {28'd0, grant}, 32'd0);
    check("rst_vld_zero", {31'd0, sel_vld}, 32'd0);
    exp_q.push_back(2'd0);
    wait_grant();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
